// File: rtl/eth_filter_pkg.sv
// eth_filter_pkg
// Shared definitions for the Ethernet header filter:
//   - EtherType constants used by the type classifier
//   - address / type class enums
//   - statistics counter indices and the broadcast MAC
//   - pure classification helpers shared by the datapath
package eth_filter_pkg;

    localparam logic [15:0] IPV4    = 16'h0800;
    localparam logic [15:0] ARP     = 16'h0806;
    localparam logic [15:0] IPV6    = 16'h86DD;
    localparam logic [15:0] VLAN_C  = 16'h8100;
    localparam logic [15:0] VLAN_S  = 16'h88A8;
    // Values below this are an 802.3 length field, not an EtherType.
    localparam logic [15:0] LEN_MAX = 16'h0600;

    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    localparam int NUM_CNT      = 8;
    localparam int CNT_RX_TOTAL = 0;
    localparam int CNT_ACCEPTED = 1;
    localparam int CNT_FILTERED = 2;
    localparam int CNT_OVERRUN  = 3;
    localparam int CNT_IPV4     = 4;
    localparam int CNT_ARP      = 5;
    localparam int CNT_IPV6     = 6;
    localparam int CNT_VLAN     = 7;

    typedef enum logic [1:0] {
        ADDR_LOCAL = 2'd0,
        ADDR_BCAST = 2'd1,
        ADDR_MCAST = 2'd2,
        ADDR_OTHER = 2'd3
    } addr_class_t;

    typedef enum logic [2:0] {
        TYPE_OTHER = 3'd0,
        TYPE_IPV4  = 3'd1,
        TYPE_ARP   = 3'd2,
        TYPE_IPV6  = 3'd3,
        TYPE_VLAN  = 3'd4,
        TYPE_LEN   = 3'd5
    } type_class_t;

    // Priority order matters: a station MAC match wins over broadcast,
    // and broadcast wins over the generic group (I/G) bit test.
    function automatic addr_class_t classify_addr(input logic [47:0] dst,
                                                  input logic [47:0] station_mac);
        addr_class_t cls;
        if (dst == station_mac) begin
            cls = ADDR_LOCAL;
        end else if (dst == BCAST_MAC) begin
            cls = ADDR_BCAST;
        end else if (dst[40]) begin
            cls = ADDR_MCAST;
        end else begin
            cls = ADDR_OTHER;
        end
        return cls;
    endfunction

    function automatic type_class_t classify_type(input logic [15:0] etype);
        type_class_t cls;
        if (etype == IPV4) begin
            cls = TYPE_IPV4;
        end else if (etype == ARP) begin
            cls = TYPE_ARP;
        end else if (etype == IPV6) begin
            cls = TYPE_IPV6;
        end else if ((etype == VLAN_C) || (etype == VLAN_S)) begin
            cls = TYPE_VLAN;
        end else if (etype < LEN_MAX) begin
            cls = TYPE_LEN;
        end else begin
            cls = TYPE_OTHER;
        end
        return cls;
    endfunction

endpackage

// File: rtl/eth_header_filter_if.sv
// eth_header_filter_if
// Output stream of the header filter: one accepted, classified header per
// valid/ready transfer.
//   m_valid       accepted header available (source -> sink)
//   m_ready       sink accepts; transfer when m_valid & m_ready
//   m_addr_class  0 local, 1 broadcast, 2 multicast, 3 other unicast
//   m_type_class  0 other, 1 IPv4, 2 ARP, 3 IPv6, 4 VLAN, 5 802.3 length
//   m_src_mac     source MAC of the header
//   m_eth_type    raw EtherType of the header
interface eth_header_filter_if;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  m_addr_class;
    logic [2:0]  m_type_class;
    logic [47:0] m_src_mac;
    logic [15:0] m_eth_type;

    modport master (
        output m_valid, m_addr_class, m_type_class, m_src_mac, m_eth_type,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_addr_class, m_type_class, m_src_mac, m_eth_type,
        output m_ready
    );
endinterface

// File: rtl/eth_sat_counter.sv
// eth_sat_counter
// Saturating up-counter. Sticks at all ones; clr wins over inc.
//   clk   clock
//   clr   synchronous zero (priority over inc)
//   inc   count enable
//   q     current count
module eth_sat_counter #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               inc,
    output logic [COUNT_W-1:0] q
);

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {COUNT_W{1'b1}})) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign q = count_q;

endmodule

// File: rtl/eth_header_filter.sv
// eth_header_filter
// Classifies parsed Ethernet headers, filters them against the station MAC
// and accept flags, and forwards accepted headers through a two-stage
// (S1 -> OUT) pipeline onto a valid/ready stream. Keeps saturating stats.
//   clk, clear          clock and synchronous active-high reset
//   hdr_valid, dst_mac, src_mac, eth_type   parser bundle (rising edge = event)
//   cfg_local_mac/cfg_we                    station MAC load
//   cfg_promisc, cfg_accept_bcast, cfg_accept_mcast   accept flags
//   cnt_sel, cnt_clear, cnt_value           statistics read / clear
//   m_if                                    accepted header stream
module eth_header_filter
    import eth_filter_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               hdr_valid,
    input  logic [47:0]        dst_mac,
    input  logic [47:0]        src_mac,
    input  logic [15:0]        eth_type,
    input  logic [47:0]        cfg_local_mac,
    input  logic               cfg_we,
    input  logic               cfg_promisc,
    input  logic               cfg_accept_bcast,
    input  logic               cfg_accept_mcast,
    input  logic [2:0]         cnt_sel,
    input  logic               cnt_clear,
    output logic [COUNT_W-1:0] cnt_value,
    eth_header_filter_if.master m_if
);

    logic               hdr_valid_prev_q, hdr_valid_prev_d;
    logic [47:0]        local_mac_q, local_mac_d;

    logic               s1_valid_q, s1_valid_d;
    addr_class_t        s1_addr_q, s1_addr_d;
    type_class_t        s1_type_q, s1_type_d;
    logic [47:0]        s1_src_q, s1_src_d;
    logic [15:0]        s1_etype_q, s1_etype_d;

    logic               out_valid_q, out_valid_d;
    addr_class_t        out_addr_q, out_addr_d;
    type_class_t        out_type_q, out_type_d;
    logic [47:0]        out_src_q, out_src_d;
    logic [15:0]        out_etype_q, out_etype_d;

    logic [COUNT_W-1:0] cnt_value_q, cnt_value_d;

    logic               hdr_event;
    addr_class_t        hdr_addr;
    type_class_t        hdr_type;
    logic               hdr_accept;
    logic               out_free;
    logic               s1_adv;
    logic               s1_free;
    logic               take;

    logic [NUM_CNT-1:0] cnt_inc;
    logic               cnt_clr;
    logic [COUNT_W-1:0] cnt_arr [NUM_CNT];

    always_comb begin
        hdr_valid_prev_d = hdr_valid;
        local_mac_d      = cfg_we ? cfg_local_mac : local_mac_q;

        hdr_event  = hdr_valid & ~hdr_valid_prev_q;
        // Classification uses the registered station MAC, so a write only
        // affects events sampled after the write cycle.
        hdr_addr   = classify_addr(dst_mac, local_mac_q);
        hdr_type   = classify_type(eth_type);
        hdr_accept = cfg_promisc
                   | (hdr_addr == ADDR_LOCAL)
                   | ((hdr_addr == ADDR_BCAST) & cfg_accept_bcast)
                   | ((hdr_addr == ADDR_MCAST) & cfg_accept_mcast);

        // OUT can take S1 when empty or when its current beat leaves now.
        out_free = ~out_valid_q | m_if.m_ready;
        s1_adv   = s1_valid_q & out_free;
        s1_free  = ~s1_valid_q | s1_adv;
        take     = hdr_event & hdr_accept & s1_free;

        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_type_d  = out_type_q;
        out_src_d   = out_src_q;
        out_etype_d = out_etype_q;
        if (s1_adv) begin
            out_valid_d = 1'b1;
            out_addr_d  = s1_addr_q;
            out_type_d  = s1_type_q;
            out_src_d   = s1_src_q;
            out_etype_d = s1_etype_q;
        end else if (out_valid_q & m_if.m_ready) begin
            out_valid_d = 1'b0;
        end

        s1_valid_d = s1_valid_q;
        s1_addr_d  = s1_addr_q;
        s1_type_d  = s1_type_q;
        s1_src_d   = s1_src_q;
        s1_etype_d = s1_etype_q;
        if (take) begin
            s1_valid_d = 1'b1;
            s1_addr_d  = hdr_addr;
            s1_type_d  = hdr_type;
            s1_src_d   = src_mac;
            s1_etype_d = eth_type;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // A rejected header is counted as filtered even when S1 is blocked;
        // overrun only applies to headers that would otherwise be forwarded.
        cnt_inc               = '0;
        cnt_inc[CNT_RX_TOTAL] = hdr_event;
        cnt_inc[CNT_ACCEPTED] = take;
        cnt_inc[CNT_FILTERED] = hdr_event & ~hdr_accept;
        cnt_inc[CNT_OVERRUN]  = hdr_event & hdr_accept & ~s1_free;
        cnt_inc[CNT_IPV4]     = take & (hdr_type == TYPE_IPV4);
        cnt_inc[CNT_ARP]      = take & (hdr_type == TYPE_ARP);
        cnt_inc[CNT_IPV6]     = take & (hdr_type == TYPE_IPV6);
        cnt_inc[CNT_VLAN]     = take & (hdr_type == TYPE_VLAN);

        cnt_value_d = cnt_arr[cnt_sel];
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            hdr_valid_prev_q <= 1'b0;
            local_mac_q      <= '0;
            s1_valid_q       <= 1'b0;
            s1_addr_q        <= ADDR_LOCAL;
            s1_type_q        <= TYPE_OTHER;
            s1_src_q         <= '0;
            s1_etype_q       <= '0;
            out_valid_q      <= 1'b0;
            out_addr_q       <= ADDR_LOCAL;
            out_type_q       <= TYPE_OTHER;
            out_src_q        <= '0;
            out_etype_q      <= '0;
            cnt_value_q      <= '0;
        end else begin
            hdr_valid_prev_q <= hdr_valid_prev_d;
            local_mac_q      <= local_mac_d;
            s1_valid_q       <= s1_valid_d;
            s1_addr_q        <= s1_addr_d;
            s1_type_q        <= s1_type_d;
            s1_src_q         <= s1_src_d;
            s1_etype_q       <= s1_etype_d;
            out_valid_q      <= out_valid_d;
            out_addr_q       <= out_addr_d;
            out_type_q       <= out_type_d;
            out_src_q        <= out_src_d;
            out_etype_q      <= out_etype_d;
            cnt_value_q      <= cnt_value_d;
        end
    end

    assign cnt_clr = clear | cnt_clear;

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            eth_sat_counter #(
                .COUNT_W (COUNT_W)
            ) u_cnt (
                .clk (clk),
                .clr (cnt_clr),
                .inc (cnt_inc[gi]),
                .q   (cnt_arr[gi])
            );
        end
    endgenerate

    assign m_if.m_valid      = out_valid_q;
    assign m_if.m_addr_class = out_addr_q;
    assign m_if.m_type_class = out_type_q;
    assign m_if.m_src_mac    = out_src_q;
    assign m_if.m_eth_type   = out_etype_q;
    assign cnt_value         = cnt_value_q;

endmodule
